inttofp_wb: RTL and testbench

- Result writeback stage directly downstream of the inttofp converter.
- Captures each 128-bit converted vector together with its control word and destination register index.
- Packs 32→16 results (which fill only the low 64 bits) in pairs into full 128-bit words.
- Buffers results in a small FIFO and issues byte-enabled writes to the vector register file over a valid/ready port.

---
 rtl/inttofp_wb.sv | 177 +++++++++++++++++
 tb/tb_inttofp_wb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inttofp_wb.sv
// Writeback stage behind the int-to-fp converter: pairs narrow (32->16) halves into
// full vector words, queues them and issues byte-enabled register-file writes.
// Optional statistics counters are enabled with `define INTTOFP_WB_STATS_EN.
module inttofp_wb #(
  parameter int DEPTH        = 4,
  parameter int IDX_W        = 5,
  parameter int PACK_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [127:0]     res_data,
  input  logic [5:0]       res_ctrl,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             drain,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [127:0]     wb_data,
  output logic [15:0]      wb_be,
  output logic [IDX_W-1:0] wb_idx,
  output logic             busy
`ifdef INTTOFP_WB_STATS_EN
  ,
  output logic [31:0]      stat_wr_cnt,
  output logic [31:0]      stat_pair_cnt,
  output logic [31:0]      stat_partial_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(PACK_TIMEOUT + 1);
  localparam int EW = 128 + 16 + IDX_W;
  localparam logic [TW-1:0] TMAX = TW'(PACK_TIMEOUT - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [63:0]      r_hold_lo;
  logic [IDX_W-1:0] r_hold_idx;
  logic [TW-1:0]    r_timer;
  logic             r_drain_pend;

  logic             w_accept, w_beat, w_narrow, w_same_idx, w_pop;
  logic             w_flush, w_pair, w_partial;
  logic [1:0]       w_n_push;
  logic [PW-1:0]    w_wr_ptr1;
  logic [EW-1:0]    w_e0, w_e1, w_full_e, w_part_e, w_pair_e, w_head;

  // Credit check uses the registered count only; a pop in the same cycle is not counted.
  assign res_ready  = ~rst & (r_count <= CW'(DEPTH - 2));
  assign w_accept   = res_valid & res_ready;
  assign w_beat     = w_accept & res_ctrl[5];
  assign w_narrow   = res_ctrl[4] & ~res_ctrl[3];
  assign w_same_idx = (res_idx == r_hold_idx);
  assign w_pop      = (r_count != '0) & wb_ready;
  assign w_wr_ptr1  = r_wr_ptr + PW'(1);

  assign w_full_e = {res_data, 16'hFFFF, res_idx};
  assign w_part_e = {64'h0, r_hold_lo, 16'h00FF, r_hold_idx};
  assign w_pair_e = {res_data[63:0], r_hold_lo, 16'hFFFF, r_hold_idx};

  assign w_head   = r_mem[r_rd_ptr];
  assign wb_valid = (r_count != '0);
  assign wb_data  = wb_valid ? w_head[EW-1 -: 128] : 128'h0;
  assign wb_be    = wb_valid ? w_head[IDX_W +: 16] : 16'h0;
  assign wb_idx   = wb_valid ? w_head[IDX_W-1:0] : '0;
  assign busy     = (r_state == HOLD) | (r_count != '0);

  always_comb begin
    w_n_push = 2'd0;
    w_e0     = w_full_e;
    w_e1     = w_full_e;
    w_flush  = 1'b0;
    w_pair   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_beat && !w_narrow) w_n_push = 2'd1;
      end
      HOLD: begin
        if (w_beat) begin
          if (w_narrow && w_same_idx) begin
            w_n_push = 2'd1;
            w_e0     = w_pair_e;
            w_pair   = 1'b1;
          end else if (w_narrow) begin
            w_n_push = 2'd1;
            w_e0     = w_part_e;
          end else begin
            w_n_push = 2'd2;
            w_e0     = w_part_e;
            w_e1     = w_full_e;
          end
        end else if ((drain || r_drain_pend || r_timer == TMAX) && (r_count < CW'(DEPTH))) begin
          w_n_push = 2'd1;
          w_e0     = w_part_e;
          w_flush  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign w_partial = (r_state == HOLD) && ((w_beat && !(w_narrow && w_same_idx)) || w_flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_hold_lo    <= '0;
      r_hold_idx   <= '0;
      r_timer      <= '0;
      r_drain_pend <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_n_push != 2'd0) r_mem[r_wr_ptr] <= w_e0;
      if (w_n_push == 2'd2) r_mem[w_wr_ptr1] <= w_e1;
      r_wr_ptr <= r_wr_ptr + PW'(w_n_push);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_n_push) - CW'(w_pop);

      case (r_state)
        IDLE: begin
          if (w_beat && w_narrow) begin
            r_state      <= HOLD;
            r_hold_lo    <= res_data[63:0];
            r_hold_idx   <= res_idx;
            r_timer      <= '0;
            r_drain_pend <= drain;
          end
        end
        HOLD: begin
          if (w_beat) begin
            if (w_narrow && !w_same_idx) begin
              r_hold_lo    <= res_data[63:0];
              r_hold_idx   <= res_idx;
              r_timer      <= '0;
              r_drain_pend <= drain;
            end else begin
              r_state      <= IDLE;
              r_drain_pend <= 1'b0;
            end
          end else if (w_flush) begin
            r_state      <= IDLE;
            r_drain_pend <= 1'b0;
          end else if (r_timer != TMAX) begin
            // Holds at the last count while the FIFO is full, so the flush fires once space frees.
            r_timer <= r_timer + TW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef INTTOFP_WB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_wr_cnt      <= '0;
      stat_pair_cnt    <= '0;
      stat_partial_cnt <= '0;
    end else begin
      if (w_pop)     stat_wr_cnt      <= stat_wr_cnt + 32'd1;
      if (w_pair)    stat_pair_cnt    <= stat_pair_cnt + 32'd1;
      if (w_partial) stat_partial_cnt <= stat_partial_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inttofp_wb.sv
// Directed bench for inttofp_wb: vector table for single full beats plus
// hand-written sequences for pairing, timeout, drain, backpressure and reset.
module tb_inttofp_wb;

  logic         clk;
  logic         rst;
  logic         res_valid;
  logic         res_ready;
  logic [127:0] res_data;
  logic [5:0]   res_ctrl;
  logic [4:0]   res_idx;
  logic         drain;
  logic         wb_valid;
  logic         wb_ready;
  logic [127:0] wb_data;
  logic [15:0]  wb_be;
  logic [4:0]   wb_idx;
  logic         busy;
`ifdef INTTOFP_WB_STATS_EN
  logic [31:0]  stat_wr_cnt, stat_pair_cnt, stat_partial_cnt;
`endif

  int errors = 0;
  int checks = 0;

  inttofp_wb #(.DEPTH(4), .IDX_W(5), .PACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_ctrl(res_ctrl), .res_idx(res_idx), .drain(drain),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_be(wb_be), .wb_idx(wb_idx), .busy(busy)
`ifdef INTTOFP_WB_STATS_EN
    , .stat_wr_cnt(stat_wr_cnt), .stat_pair_cnt(stat_pair_cnt),
    .stat_partial_cnt(stat_partial_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] C_NARROW = 6'b110100;
  localparam logic [5:0] C_F16    = 6'b100000;
  localparam logic [63:0] A = 64'h3C00_BC00_7BFF_0000;
  localparam logic [63:0] B = 64'h4000_C000_0000_3C00;
  localparam logic [63:0] C = 64'h1234_5678_9ABC_DEF0;

  typedef struct {
    logic [127:0] data;
    logic [5:0]   ctrl;
    logic [4:0]   idx;
    logic         exp_v;
    logic [127:0] exp_data;
    logic [15:0]  exp_be;
    logic [4:0]   exp_idx;
  } vec_t;

  vec_t vt[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    res_valid = 1'b0;
    res_data  = '0;
    res_ctrl  = '0;
    res_idx   = '0;
    drain     = 1'b0;
  endtask

  task automatic drive(input logic [127:0] d, input logic [5:0] c, input logic [4:0] i);
    res_valid = 1'b1;
    res_data  = d;
    res_ctrl  = c;
    res_idx   = i;
  endtask

  function automatic logic [127:0] bp_data(input int j);
    return {4{32'hC0DE0000 + 32'(j)}};
  endfunction

  task automatic run_timeout(input string name, input bit use_drain, input int exp_cycle);
    int seen;
    seen = 0;
    drive({64'hFFFF_FFFF_FFFF_FFFF, A}, C_NARROW, 5'd5);
    tick();
    idle_inputs();
    for (int k = 1; k <= 20; k++) begin
      if (wb_valid) begin
        seen = k;
        break;
      end
      drain = use_drain && (k == 2);
      tick();
    end
    drain = 1'b0;
    chk({name, "_cycle"}, 128'(seen), 128'(exp_cycle));
    chk({name, "_be"}, 128'(wb_be), 128'(16'h00FF));
    chk({name, "_data"}, wb_data, {64'h0, A});
    tick();
    chk({name, "_done"}, 128'(busy), 128'(0));
  endtask

  initial begin
    vt[0] = '{128'h3F800000_BF800000_4F000000_00000000, 6'b111100, 5'd3, 1'b1,
              128'h3F800000_BF800000_4F000000_00000000, 16'hFFFF, 5'd3};
    vt[1] = '{128'h0001_0002_0003_0004_0005_0006_0007_0008, 6'b100000, 5'd0, 1'b1,
              128'h0001_0002_0003_0004_0005_0006_0007_0008, 16'hFFFF, 5'd0};
    vt[2] = '{128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 6'b101101, 5'd31, 1'b1,
              128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 16'hFFFF, 5'd31};
    vt[3] = '{128'h11111111_22222222_33333333_44444444, 6'b111111, 5'd7, 1'b1,
              128'h11111111_22222222_33333333_44444444, 16'hFFFF, 5'd7};
    vt[4] = '{128'h55555555_66666666_77777777_88888888, 6'b011100, 5'd9, 1'b0,
              128'h0, 16'h0, 5'd0};

    idle_inputs();
    wb_ready = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_res_ready", 128'(res_ready), 128'(0));
    chk("rst_wb_valid", 128'(wb_valid), 128'(0));
    chk("rst_wb_data", wb_data, 128'h0);
    chk("rst_wb_be", 128'(wb_be), 128'(0));
    chk("rst_wb_idx", 128'(wb_idx), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 128'(res_ready), 128'(1));

    // single full beats, including a discarded (op-invalid) one
    for (int i = 0; i < 5; i++) begin
      drive(vt[i].data, vt[i].ctrl, vt[i].idx);
      tick();
      idle_inputs();
      chk($sformatf("vec%0d_valid", i), 128'(wb_valid), 128'(vt[i].exp_v));
      if (vt[i].exp_v) begin
        chk($sformatf("vec%0d_data", i), wb_data, vt[i].exp_data);
        chk($sformatf("vec%0d_be", i), 128'(wb_be), 128'(vt[i].exp_be));
        chk($sformatf("vec%0d_idx", i), 128'(wb_idx), 128'(vt[i].exp_idx));
      end
      tick();
      chk($sformatf("vec%0d_empty", i), 128'(wb_valid), 128'(0));
    end

    // narrow pair, same index: one merged write
    drive({64'hAAAA_AAAA_AAAA_AAAA, A}, C_NARROW, 5'd5);
    tick();
    chk("pair_hold_valid", 128'(wb_valid), 128'(0));
    chk("pair_hold_busy", 128'(busy), 128'(1));
    drive({64'h5555_5555_5555_5555, B}, C_NARROW, 5'd5);
    tick();
    idle_inputs();
    chk("pair_valid", 128'(wb_valid), 128'(1));
    chk("pair_data", wb_data, {B, A});
    chk("pair_be", 128'(wb_be), 128'(16'hFFFF));
    chk("pair_idx", 128'(wb_idx), 128'(5));
    tick();
    chk("pair_single", 128'(wb_valid), 128'(0));
    chk("pair_idle", 128'(busy), 128'(0));

    // narrow then full: partial first, then the full beat
    drive({64'h0, A}, C_NARROW, 5'd5);
    tick();
    drive({B, C}, C_F16, 5'd6);
    tick();
    idle_inputs();
    chk("nf_part_data", wb_data, {64'h0, A});
    chk("nf_part_be", 128'(wb_be), 128'(16'h00FF));
    chk("nf_part_idx", 128'(wb_idx), 128'(5));
    tick();
    chk("nf_full_data", wb_data, {B, C});
    chk("nf_full_be", 128'(wb_be), 128'(16'hFFFF));
    chk("nf_full_idx", 128'(wb_idx), 128'(6));
    tick();
    chk("nf_empty", 128'(wb_valid), 128'(0));

    // narrow, different-index narrow with drain: both flushed as partials
    drive({64'h0, A}, C_NARROW, 5'd5);
    tick();
    drive({64'h0, C}, C_NARROW, 5'd9);
    drain = 1'b1;
    tick();
    idle_inputs();
    chk("dd_first_data", wb_data, {64'h0, A});
    chk("dd_first_idx", 128'(wb_idx), 128'(5));
    tick();
    chk("dd_second_data", wb_data, {64'h0, C});
    chk("dd_second_be", 128'(wb_be), 128'(16'h00FF));
    chk("dd_second_idx", 128'(wb_idx), 128'(9));
    tick();
    chk("dd_idle", 128'(busy), 128'(0));

    run_timeout("timeout", 1'b0, 9);
    run_timeout("drain", 1'b1, 3);

    // backpressure: six full beats with wb_ready held low first
    begin
      int j, got;
      bit acc;
      j = 0;
      got = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
        if (got == 6) break;
        wb_ready = (cyc >= 6);
        if (j < 6) drive(bp_data(j), C_F16, 5'(j));
        else idle_inputs();
        #1;
        if (cyc == 5) begin
          chk("bp_ready_low", 128'(res_ready), 128'(0));
          chk("bp_accepted", 128'(j), 128'(3));
        end
        acc = res_valid && res_ready;
        if (wb_valid && wb_ready) begin
          chk($sformatf("bp_data%0d", got), wb_data, bp_data(got));
          chk($sformatf("bp_idx%0d", got), 128'(wb_idx), 128'(got));
          got++;
        end
        tick();
        if (acc) j++;
      end
      idle_inputs();
      chk("bp_all_out", 128'(got), 128'(6));
      chk("bp_all_in", 128'(j), 128'(6));
      chk("bp_empty", 128'(wb_valid), 128'(0));
    end

    // reset while a narrow half is held: nothing is ever written
    begin
      bit seen;
      seen = 1'b0;
      wb_ready = 1'b1;
      drive({64'h0, A}, C_NARROW, 5'd5);
      tick();
      idle_inputs();
      tick();
      tick();
      rst = 1'b1;
      #1;
      chk("rh_ready_in_rst", 128'(res_ready), 128'(0));
      tick();
      rst = 1'b0;
      #1;
      chk("rh_busy", 128'(busy), 128'(0));
      chk("rh_ready", 128'(res_ready), 128'(1));
      for (int k = 0; k < 12; k++) begin
        if (wb_valid) seen = 1'b1;
        tick();
      end
      chk("rh_no_write", 128'(seen), 128'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
